// File: rtl/sdram_arb.sv
// sdram_arb: round-robin arbiter serialising two SDRAM requesters onto one sdram_intf,
// routing acks and read beats back to the owning port, with a per-transaction watchdog.
module sdram_arb #(
  parameter int BURST = 1,
  parameter int TMO   = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_wr_req,
  input  logic        p0_rd_req,
  input  logic [1:0]  p0_bank,
  input  logic [12:0] p0_addr,
  input  logic [15:0] p0_wdata,
  input  logic        p1_wr_req,
  input  logic        p1_rd_req,
  input  logic [1:0]  p1_bank,
  input  logic [12:0] p1_addr,
  input  logic [15:0] p1_wdata,
  output logic        p0_wr_ack,
  output logic        p0_rd_ack,
  output logic        p0_rdata_vld,
  output logic        p1_wr_ack,
  output logic        p1_rd_ack,
  output logic        p1_rdata_vld,
  output logic [15:0] rdata,
  output logic        sd_wr_req,
  output logic        sd_rd_req,
  output logic [1:0]  sd_bank,
  output logic [12:0] sd_addr,
  output logic [15:0] sd_wdata,
  input  logic        sd_wr_ack,
  input  logic        sd_rd_ack,
  input  logic [15:0] sd_rdata,
  input  logic        sd_rdata_vld,
  output logic [1:0]  owner,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, REQ, RDATA} state_t;
  state_t      state;
  logic        op_wr, last;
  logic [9:0]  wdog;
  logic [3:0]  beats, beats_n;
  logic        pend0, pend1, gnt1, wr_hit, rd_hit, fin, tmo;
  always_comb begin
    pend0   = p0_wr_req | p0_rd_req;
    pend1   = p1_wr_req | p1_rd_req;
    gnt1    = pend1 & (~pend0 | ~last);
    wr_hit  = (state == REQ) && op_wr && sd_wr_ack;
    rd_hit  = (state == REQ) && !op_wr && sd_rd_ack;
    beats_n = beats + {3'd0, sd_rdata_vld};
    fin     = wr_hit || ((rd_hit || state == RDATA) && beats_n >= 4'(BURST));
    tmo     = wdog == 10'(TMO - 1);
  end
  // owner is zero while idle, so stray acks and beats are dropped there
  assign p0_wr_ack    = wr_hit & owner[0];
  assign p1_wr_ack    = wr_hit & owner[1];
  assign p0_rd_ack    = rd_hit & owner[0];
  assign p1_rd_ack    = rd_hit & owner[1];
  assign p0_rdata_vld = sd_rdata_vld & owner[0];
  assign p1_rdata_vld = sd_rdata_vld & owner[1];
  assign rdata        = sd_rdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 2'b00;
      last      <= 1'b1;
      op_wr     <= 1'b0;
      sd_wr_req <= 1'b0;
      sd_rd_req <= 1'b0;
      sd_bank   <= '0;
      sd_addr   <= '0;
      sd_wdata  <= '0;
      wdog      <= '0;
      beats     <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (state == IDLE) begin
        if (pend0 | pend1) begin
          state     <= REQ;
          owner     <= gnt1 ? 2'b10 : 2'b01;
          last      <= gnt1;
          op_wr     <= gnt1 ? p1_wr_req : p0_wr_req;
          sd_wr_req <= gnt1 ? p1_wr_req : p0_wr_req;
          sd_rd_req <= gnt1 ? ~p1_wr_req : ~p0_wr_req;
          sd_bank   <= gnt1 ? p1_bank : p0_bank;
          sd_addr   <= gnt1 ? p1_addr : p0_addr;
          sd_wdata  <= gnt1 ? p1_wdata : p0_wdata;
          wdog      <= '0;
          beats     <= '0;
        end
      end else begin
        wdog  <= wdog + 10'd1;
        beats <= beats_n;
        // a real completion in the expiry cycle wins over the watchdog
        if (fin || tmo) begin
          state     <= IDLE;
          owner     <= 2'b00;
          sd_wr_req <= 1'b0;
          sd_rd_req <= 1'b0;
          err       <= !fin;
        end else if (rd_hit) begin
          state     <= RDATA;
          sd_rd_req <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_sdram_arb.sv
// tb_sdram_arb: directed and randomized transactions checked against a transaction-level
// round-robin model (pending set + last-granted port) with BURST=4, TMO=20.
module tb_sdram_arb;
  localparam int BURST = 4;
  localparam int TMO   = 20;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        p0_wr_req, p0_rd_req, p1_wr_req, p1_rd_req;
  logic [1:0]  p0_bank, p1_bank;
  logic [12:0] p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic        p0_wr_ack, p0_rd_ack, p0_rdata_vld, p1_wr_ack, p1_rd_ack, p1_rdata_vld;
  logic [15:0] rdata;
  logic        sd_wr_req, sd_rd_req;
  logic [1:0]  sd_bank;
  logic [12:0] sd_addr;
  logic [15:0] sd_wdata;
  logic        sd_wr_ack = 1'b0, sd_rd_ack = 1'b0, sd_rdata_vld = 1'b0;
  logic [15:0] sd_rdata = '0;
  logic [1:0]  owner;
  logic        err;

  always #5 clk = ~clk;

  sdram_arb #(.BURST(BURST), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_wr_req(p0_wr_req), .p0_rd_req(p0_rd_req), .p0_bank(p0_bank), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_wr_req(p1_wr_req), .p1_rd_req(p1_rd_req), .p1_bank(p1_bank), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_wr_ack(p0_wr_ack), .p0_rd_ack(p0_rd_ack), .p0_rdata_vld(p0_rdata_vld),
    .p1_wr_ack(p1_wr_ack), .p1_rd_ack(p1_rd_ack), .p1_rdata_vld(p1_rdata_vld),
    .rdata(rdata), .sd_wr_req(sd_wr_req), .sd_rd_req(sd_rd_req),
    .sd_bank(sd_bank), .sd_addr(sd_addr), .sd_wdata(sd_wdata),
    .sd_wr_ack(sd_wr_ack), .sd_rd_ack(sd_rd_ack), .sd_rdata(sd_rdata), .sd_rdata_vld(sd_rdata_vld),
    .owner(owner), .err(err)
  );

  int          tests = 0, fails = 0;
  bit          wr_m[2], rd_m[2];
  logic [1:0]  bank_m[2];
  logic [12:0] addr_m[2];
  logic [15:0] wdata_m[2];
  bit          last_m = 1'b1;
  int          cur_p;
  bit          cur_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    p0_wr_req = wr_m[0]; p0_rd_req = rd_m[0]; p0_bank = bank_m[0]; p0_addr = addr_m[0]; p0_wdata = wdata_m[0];
    p1_wr_req = wr_m[1]; p1_rd_req = rd_m[1]; p1_bank = bank_m[1]; p1_addr = addr_m[1]; p1_wdata = wdata_m[1];
  endtask

  task automatic req(input int p, input bit w, input bit r, input logic [1:0] b,
                     input logic [12:0] a, input logic [15:0] d);
    wr_m[p] = w; rd_m[p] = r; bank_m[p] = b; addr_m[p] = a; wdata_m[p] = d;
    drive();
  endtask

  task automatic rand_req(input int p);
    int o;
    o = int'($urandom_range(0, 2));
    req(p, o != 1, o != 0, 2'($urandom), 13'($urandom), 16'($urandom));
  endtask

  // round robin: a lone pending port wins; on a tie the port that did not go last wins
  function automatic int pick();
    bit a, b;
    a = wr_m[0] | rd_m[0];
    b = wr_m[1] | rd_m[1];
    return (a && b) ? int'(!last_m) : (b ? 1 : 0);
  endfunction

  task automatic grant();
    cur_p  = pick();
    cur_w  = wr_m[cur_p];
    last_m = cur_p[0];
    #1;
    chk("pre_grant_owner", 32'(owner), 0);
    cyc();
    #1;
    chk("grant_owner", 32'(owner), 32'(1 << cur_p));
    chk("grant_sd_wr_req", 32'(sd_wr_req), 32'(cur_w));
    chk("grant_sd_rd_req", 32'(sd_rd_req), 32'(!cur_w));
    chk("grant_bank", 32'(sd_bank), 32'(bank_m[cur_p]));
    chk("grant_addr", 32'(sd_addr), 32'(addr_m[cur_p]));
    chk("grant_wdata", 32'(sd_wdata), 32'(wdata_m[cur_p]));
    chk("grant_err", 32'(err), 0);
  endtask

  task automatic do_write(input int d, input bit glitch);
    for (int i = 1; i <= d; i++) begin
      cyc();
      sd_rd_ack = glitch && i == 1 && d > 1;
      if (i < d) begin
        #1;
        chk("wr_wait_acks", 32'({p1_rd_ack, p0_rd_ack, p1_wr_ack, p0_wr_ack}), 0);
        chk("wr_wait_owner", 32'(owner), 32'(1 << cur_p));
      end
    end
    sd_rd_ack = 1'b0;
    sd_wr_ack = 1'b1;
    #1;
    chk("wr_ack", 32'({p1_wr_ack, p0_wr_ack}), 32'(1 << cur_p));
    chk("wr_ack_rd_quiet", 32'({p1_rd_ack, p0_rd_ack}), 0);
    cyc();
    sd_wr_ack = 1'b0;
    wr_m[cur_p] = 1'b0;
    drive();
    #1;
    chk("wr_release_owner", 32'(owner), 0);
    chk("wr_release_req", 32'(sd_wr_req), 0);
  endtask

  task automatic do_read(input int d, input bit early, input bit rnd);
    int left, n;
    logic [15:0] dat;
    left = BURST;
    n = 0;
    dat = '0;
    for (int i = 1; i <= d; i++) begin
      cyc();
      if (i < d) begin
        #1;
        chk("rd_wait_acks", 32'({p1_rd_ack, p0_rd_ack}), 0);
      end
    end
    sd_rd_ack = 1'b1;
    if (early) begin
      n++;
      dat = rnd ? 16'($urandom) : 16'(n);
      sd_rdata_vld = 1'b1;
      sd_rdata = dat;
      left--;
    end
    #1;
    chk("rd_ack", 32'({p1_rd_ack, p0_rd_ack}), 32'(1 << cur_p));
    chk("rd_ack_wr_quiet", 32'({p1_wr_ack, p0_wr_ack}), 0);
    if (early) begin
      chk("early_vld", 32'({p1_rdata_vld, p0_rdata_vld}), 32'(1 << cur_p));
      chk("early_rdata", 32'(rdata), 32'(dat));
    end
    cyc();
    sd_rd_ack = 1'b0;
    sd_rdata_vld = 1'b0;
    rd_m[cur_p] = 1'b0;
    drive();
    while (left > 0) begin
      repeat ($urandom_range(0, 2)) begin
        #1;
        chk("gap_vld", 32'({p1_rdata_vld, p0_rdata_vld}), 0);
        chk("gap_owner", 32'(owner), 32'(1 << cur_p));
        cyc();
      end
      n++;
      dat = rnd ? 16'($urandom) : 16'(n);
      sd_rdata_vld = 1'b1;
      sd_rdata = dat;
      #1;
      chk("beat_vld", 32'({p1_rdata_vld, p0_rdata_vld}), 32'(1 << cur_p));
      chk("beat_rdata", 32'(rdata), 32'(dat));
      cyc();
      sd_rdata_vld = 1'b0;
      left--;
    end
    #1;
    chk("rd_release_owner", 32'(owner), 0);
  endtask

  task automatic do_timeout(input bit keep);
    for (int k = 1; k <= TMO; k++) begin
      cyc();
      #1;
      chk("tmo_err", 32'(err), 32'(k == TMO));
      chk("tmo_no_ack", 32'({p1_wr_ack, p0_wr_ack, p1_rd_ack, p0_rd_ack}), 0);
    end
    chk("tmo_owner", 32'(owner), 0);
    chk("tmo_sd_req", 32'({sd_wr_req, sd_rd_req}), 0);
    if (!keep) begin
      wr_m[cur_p] = 1'b0;
      rd_m[cur_p] = 1'b0;
      drive();
    end
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      wr_m[p] = 1'b0; rd_m[p] = 1'b0; bank_m[p] = '0; addr_m[p] = '0; wdata_m[p] = '0;
    end
    drive();
    #1;
    chk("rst_owner", 32'(owner), 0);
    chk("rst_sd_req", 32'({sd_wr_req, sd_rd_req}), 0);
    chk("rst_sd_fields", 32'({sd_bank, sd_addr, sd_wdata}), 0);
    chk("rst_port_outs", 32'({p1_wr_ack, p1_rd_ack, p1_rdata_vld, p0_wr_ack, p0_rd_ack, p0_rdata_vld}), 0);
    chk("rst_err", 32'(err), 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    // single write with a wrong-type ack injected while waiting
    req(0, 1'b1, 1'b0, 2'd1, 13'h0123, 16'hA5A5);
    grant();
    do_write(5, 1'b1);
    // tie round robin with both ports holding writes
    req(0, 1'b1, 1'b0, 2'($urandom), 13'($urandom), 16'($urandom));
    req(1, 1'b1, 1'b0, 2'($urandom), 13'($urandom), 16'($urandom));
    for (int i = 0; i < 4; i++) begin
      grant();
      do_write(2, 1'b0);
      if (i < 3) req(cur_p, 1'b1, 1'b0, 2'($urandom), 13'($urandom), 16'($urandom));
    end
    grant();
    do_write(1, 1'b0);
    // burst read on port 1 with data 1..4
    req(1, 1'b0, 1'b1, 2'd2, 13'h1F00, 16'h0);
    grant();
    do_read(2, 1'b0, 1'b0);
    // same-port write+read: write first, read after its ack
    req(0, 1'b1, 1'b1, 2'd3, 13'h0042, 16'h1234);
    grant();
    do_write(1, 1'b0);
    grant();
    do_read(1, 1'b1, 1'b1);
    // timeout on port 0 with port 1 waiting
    req(0, 1'b1, 1'b0, 2'd0, 13'h0777, 16'hBEEF);
    grant();
    req(1, 1'b1, 1'b0, 2'd1, 13'h0888, 16'hCAFE);
    do_timeout(1'b1);
    grant();
    do_write(2, 1'b0);
    grant();
    do_write(1, 1'b0);
    // reset during RDATA
    req(1, 1'b0, 1'b1, 2'd2, 13'h1ABC, 16'h0);
    grant();
    cyc();
    sd_rd_ack = 1'b1;
    #1;
    chk("rst_mid_rd_ack", 32'(p1_rd_ack), 1);
    cyc();
    sd_rd_ack = 1'b0;
    rd_m[1] = 1'b0;
    drive();
    sd_rdata_vld = 1'b1;
    sd_rdata = 16'h0BEE;
    #1;
    chk("rst_mid_beat", 32'(p1_rdata_vld), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_owner", 32'(owner), 0);
    chk("rst_mid_vld", 32'({p1_rdata_vld, p0_rdata_vld}), 0);
    chk("rst_mid_sd", 32'({sd_rd_req, sd_wr_req, sd_addr}), 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    last_m = 1'b1;
    #1;
    chk("stray_vld", 32'({p1_rdata_vld, p0_rdata_vld}), 0);
    cyc();
    #1;
    chk("stray_vld_2", 32'({p1_rdata_vld, p0_rdata_vld}), 0);
    chk("stray_owner", 32'(owner), 0);
    sd_rdata_vld = 1'b0;
    // first tie after reset goes to port 0
    req(0, 1'b1, 1'b0, 2'($urandom), 13'($urandom), 16'($urandom));
    req(1, 1'b0, 1'b1, 2'($urandom), 13'($urandom), 16'($urandom));
    grant();
    do_write(1, 1'b0);
    grant();
    do_read(2, 1'b1, 1'b1);
    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int p = 0; p < 2; p++)
        if (!(wr_m[p] || rd_m[p]) && $urandom_range(0, 1) == 1) rand_req(p);
      if (!(wr_m[0] || rd_m[0] || wr_m[1] || rd_m[1])) rand_req(int'($urandom_range(0, 1)));
      grant();
      if ($urandom_range(0, 7) == 0) do_timeout(1'($urandom_range(0, 1)));
      else if (cur_w) do_write(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
      else do_read(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 1'b1);
    end
    for (int p = 0; p < 2; p++) begin
      wr_m[p] = 1'b0;
      rd_m[p] = 1'b0;
    end
    drive();
    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
